// File: rtl/xrv1_ifetch_seq.sv
// xrv1 fetch sequencer: word-aligned imem requests, 2-word fetch buffer, PC tracking, decode handshake.
// Compressed (16-bit) instruction support is enabled by defining XRV1_RVC_EN.
module xrv1_ifetch_seq #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvld_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] alg_data_0_o,
    output logic        alg_data_0_vld_o,
    output logic [31:0] alg_data_1_o,
    output logic        alg_data_1_vld_o,
    output logic        alg_unalgn_pc_o,
    input  logic [31:0] alg_data_i,
    input  logic        alg_data_vld_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_vld_o,
    input  logic        instr_rdy_i
);

`ifdef XRV1_RVC_EN
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] faddr_q, faddr_d;
    logic [31:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic        v0_q, v0_d, v1_q, v1_d;

    logic        gnt;
    logic        fire;
    logic        pop;
    logic [31:0] size;
    logic [31:0] pc_inc;

    assign imem_req_o  = (state_q == S_IDLE) & ~(v0_q & v1_q) & ~rst_i;
    assign imem_addr_o = faddr_q;
    assign gnt         = imem_req_o & imem_gnt_i;

    assign alg_data_0_o     = slot0_q;
    assign alg_data_0_vld_o = v0_q;
    assign alg_data_1_o     = slot1_q;
`ifdef XRV1_RVC_EN
    assign alg_data_1_vld_o = v1_q;
    assign alg_unalgn_pc_o  = pc_q[1];
    assign size             = (alg_data_i[1:0] == 2'b11) ? 32'd4 : 32'd2;
`else
    assign alg_data_1_vld_o = 1'b0;
    assign alg_unalgn_pc_o  = 1'b0;
    assign size             = 32'd4;
`endif

    assign instr_o     = alg_data_i;
    assign instr_pc_o  = pc_q;
    assign instr_vld_o = alg_data_vld_i & ~redirect_i & v0_q;
    assign fire        = instr_vld_o & instr_rdy_i;
    assign pc_inc      = pc_q + size;
    // Leaving the word held in slot0 retires it; the prefetched word moves up.
    assign pop         = fire & (pc_inc[2] != pc_q[2]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        v0_d    = v0_q;
        v1_d    = v1_q;

        case (state_q)
            S_IDLE:  if (gnt) state_d = redirect_i ? S_DROP : S_WAIT;
            S_WAIT:  if (imem_rvld_i) state_d = S_IDLE;
                     else if (redirect_i) state_d = S_DROP;
            S_DROP:  if (imem_rvld_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            slot0_d = slot1_q;
            v0_d    = v1_q;
            v1_d    = 1'b0;
        end
        // Response lands in the first free slot after any shift this cycle.
        if (imem_rvld_i && state_q == S_WAIT) begin
            if (!v0_d) begin
                slot0_d = imem_rdata_i;
                v0_d    = 1'b1;
            end else begin
                slot1_d = imem_rdata_i;
                v1_d    = 1'b1;
            end
        end

        if (fire) pc_d = pc_inc;
        if (gnt)  faddr_d = faddr_q + 32'd4;

        if (redirect_i) begin
            pc_d    = redirect_pc_i & PC_MASK;
            faddr_d = redirect_pc_i & WORD_MASK;
            v0_d    = 1'b0;
            v1_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= BOOT_ADDR & PC_MASK;
            faddr_q <= BOOT_ADDR & WORD_MASK;
            slot0_q <= 32'h0;
            slot1_q <= 32'h0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
        end
    end

endmodule

// File: tb/tb_xrv1_ifetch_seq.sv
// Directed bench for xrv1_ifetch_seq: imem responder, behavioural aligner, scoreboard of (pc, instr) on fire.
// Compressed-instruction cases run only when XRV1_RVC_EN is defined.
module tb_xrv1_ifetch_seq;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvld_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] alg_data_0_o, alg_data_1_o;
    logic        alg_data_0_vld_o, alg_data_1_vld_o, alg_unalgn_pc_o;
    logic [31:0] alg_data_i;
    logic        alg_data_vld_i;
    logic [31:0] instr_o, instr_pc_o;
    logic        instr_vld_o;
    logic        instr_rdy_i = 1'b0;

    always #5 clk = ~clk;

    bit gnt_en = 1'b1;
    assign imem_gnt_i = imem_req_o & gnt_en;

    xrv1_ifetch_seq #(.BOOT_ADDR(32'h0000_0100)) dut (
        .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvld_i(imem_rvld_i), .imem_rdata_i(imem_rdata_i),
        .alg_data_0_o(alg_data_0_o), .alg_data_0_vld_o(alg_data_0_vld_o),
        .alg_data_1_o(alg_data_1_o), .alg_data_1_vld_o(alg_data_1_vld_o),
        .alg_unalgn_pc_o(alg_unalgn_pc_o), .alg_data_i(alg_data_i), .alg_data_vld_i(alg_data_vld_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_vld_o(instr_vld_o), .instr_rdy_i(instr_rdy_i)
    );

    // Behavioural aligner sitting next to the sequencer.
    always_comb begin
        alg_data_i     = alg_data_0_o;
        alg_data_vld_i = alg_data_0_vld_o;
        if (alg_unalgn_pc_o) begin
            if (alg_data_0_o[17:16] != 2'b11) begin
                alg_data_i = {16'h0, alg_data_0_o[31:16]};
            end else begin
                alg_data_i     = {alg_data_1_o[15:0], alg_data_0_o[31:16]};
                alg_data_vld_i = alg_data_0_vld_o & alg_data_1_vld_o;
            end
        end else if (alg_data_0_o[1:0] != 2'b11) begin
            alg_data_i = {16'h0, alg_data_0_o[15:0]};
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] mem [logic [31:0]];
    int          errors = 0;
    int          checks = 0;

    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          resp_delay = 1;
    bit          hold_en = 1'b0;
    logic [31:0] hold_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[27:0], 4'h3};
    endfunction

    function automatic logic [31:0] glog(input int i);
        if (i >= gnt_log.size()) return 32'hxxxx_xxxx;
        return gnt_log[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        exp_q.push_back(e);
    endtask

    // Observe the cycle just before its posedge, then advance to the next negedge and drive the response.
    task automatic tick();
        exp_t e;
        #1;
        if (rst_i) begin
            pend = 1'b0;
        end else begin
            if (imem_req_o && imem_gnt_i) begin
                gnt_log.push_back(imem_addr_o);
                pend      = 1'b1;
                pend_addr = imem_addr_o;
                pend_cnt  = resp_delay;
            end
            if (instr_vld_o && instr_rdy_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL extra_fire: observed pc %h instr %h, required no fire", instr_pc_o, instr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("fire_pc", instr_pc_o, e.pc);
                    chk("fire_instr", instr_o, e.ins);
                end
            end
        end
        @(negedge clk);
        imem_rvld_i = 1'b0;
        if (pend && !(hold_en && pend_addr == hold_addr)) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvld_i  = 1'b1;
                imem_rdata_i = mem_word(pend_addr);
                pend         = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d pending instrs, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_gnt(input int maxc);
        int n = 0;
        #1;
        while (!(imem_req_o && imem_gnt_i) && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_gnt", imem_req_o & imem_gnt_i, 1'b1);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_i    = 1'b1;
        redirect_pc_i = a;
        tick();
        redirect_i    = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_ins, hold_pc;
        int n;
        mem[32'h0000_0100] = 32'h1234_5013;
        mem[32'h0000_0104] = 32'h00A0_0093;
        mem[32'h0000_0204] = 32'h4505_0513;
        mem[32'h0000_0000] = 32'h0001_4501;
        mem[32'h0000_0004] = 32'h0000_0013;
        mem[32'h0000_1000] = 32'h0513_0001;
        mem[32'h0000_1004] = 32'h0000_0000;

        @(negedge clk);
        #1;
        tick();
        tick();
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_ivld", instr_vld_o, 1'b0);
        chk("rst_pc", instr_pc_o, 32'h100);
        chk("rst_addr", imem_addr_o, 32'h100);
        chk("rst_v0", alg_data_0_vld_o, 1'b0);
        chk("rst_v1", alg_data_1_vld_o, 1'b0);

        // Boot fetch: gnt immediate, response next cycle, instr valid the cycle after.
        rst_i = 1'b0;
        instr_rdy_i = 1'b1;
        expect_instr(32'h100, 32'h1234_5013);
        expect_instr(32'h104, 32'h00A0_0093);
        #1;
        chk("t1_req0", imem_req_o, 1'b1);
        chk("t1_addr0", imem_addr_o, 32'h100);
        chk("t1_ivld0", instr_vld_o, 1'b0);
        tick();
        chk("t1_c1_req", imem_req_o, 1'b0);
        chk("t1_c1_ivld", instr_vld_o, 1'b0);
        tick();
        chk("t1_c2_ivld", instr_vld_o, 1'b1);
        chk("t1_c2_pc", instr_pc_o, 32'h100);
        drain(20);
        instr_rdy_i = 1'b0;
        chk("t1_gnt0", glog(0), 32'h100);
        chk("t1_gnt1", glog(1), 32'h104);

        // Back-pressure with a full buffer: no requests, outputs frozen.
        for (int i = 0; i < 8; i++) tick();
        hold_ins = instr_o;
        hold_pc  = instr_pc_o;
        chk("t5_pc", hold_pc, 32'h108);
        chk("t5_slot0", alg_data_0_o, mem_word(32'h108));
        chk("t5_slot1", alg_data_1_o, mem_word(32'h10C));
        for (int i = 0; i < 10; i++) begin
            chk("t5_req", imem_req_o, 1'b0);
            chk("t5_instr", instr_o, mem_word(32'h108));
            chk("t5_ipc", instr_pc_o, 32'h108);
            chk("t5_ivld", instr_vld_o, 1'b1);
            tick();
        end

        // Fetch address wraps silently past the top of the address space.
        redirect_to(32'hFFFF_FFFC);
        gnt_log.delete();
        expect_instr(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        instr_rdy_i = 1'b1;
        drain(20);
        instr_rdy_i = 1'b0;
        tick();
        chk("wrap_gnt0", glog(0), 32'hFFFF_FFFC);
        chk("wrap_gnt1", glog(1), 32'h0);

        // Redirect while a slow response is outstanding: stale word dropped.
        resp_delay = 3;
        redirect_to(32'h300);
        wait_gnt(20);
        gnt_log.delete();
        tick();
        redirect_to(32'h206);
        chk("t4_req_drop", imem_req_o, 1'b0);
`ifdef XRV1_RVC_EN
        chk("t4_pc", instr_pc_o, 32'h206);
        expect_instr(32'h206, 32'h0000_4505);
`else
        chk("t4_pc", instr_pc_o, 32'h204);
        expect_instr(32'h204, 32'h4505_0513);
`endif
        instr_rdy_i = 1'b1;
        drain(40);
        instr_rdy_i = 1'b0;
        chk("t4_gnt0", glog(0), 32'h300);
        chk("t4_gnt1", glog(1), 32'h204);

        // Redirect coincident with a would-be fire and a grant.
        resp_delay = 1;
        redirect_to(32'h500);
        n = 0;
        while (!instr_vld_o && n < 30) begin
            tick();
            n++;
        end
        chk("t6_pre_ivld", instr_vld_o, 1'b1);
        chk("t6_pre_req", imem_req_o, 1'b1);
        chk("t6_pre_pc", instr_pc_o, 32'h500);
        gnt_log.delete();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        instr_rdy_i   = 1'b1;
        #1;
        chk("t6_ivld_masked", instr_vld_o, 1'b0);
        tick();
        redirect_i  = 1'b0;
        instr_rdy_i = 1'b0;
        chk("t6_pc", instr_pc_o, 32'h400);
        chk("t6_req_drop", imem_req_o, 1'b0);
        chk("t6_v0", alg_data_0_vld_o, 1'b0);
        expect_instr(32'h400, mem_word(32'h400));
        instr_rdy_i = 1'b1;
        drain(20);
        instr_rdy_i = 1'b0;
        chk("t6_gnt0", glog(0), 32'h504);
        chk("t6_gnt1", glog(1), 32'h400);

`ifdef XRV1_RVC_EN
        // Mixed compressed / full-width stream from address 0.
        redirect_to(32'h0);
        expect_instr(32'h0, 32'h0000_4501);
        expect_instr(32'h2, 32'h0000_0001);
        expect_instr(32'h4, 32'h0000_0013);
        instr_rdy_i = 1'b1;
        drain(30);
        instr_rdy_i = 1'b0;

        // Unaligned 32-bit instruction waits for its second word.
        hold_en   = 1'b1;
        hold_addr = 32'h1004;
        redirect_to(32'h1002);
        instr_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_ivld_wait", instr_vld_o, 1'b0);
            tick();
        end
        chk("t3_unalgn", alg_unalgn_pc_o, 1'b1);
        expect_instr(32'h1002, 32'h0000_0513);
        hold_en = 1'b0;
        drain(20);
        instr_rdy_i = 1'b0;
`endif

        // Reset with a response outstanding: everything back to boot state.
        resp_delay = 3;
        redirect_to(32'h600);
        wait_gnt(20);
        tick();
        rst_i = 1'b1;
        tick();
        chk("mrst_req", imem_req_o, 1'b0);
        chk("mrst_pc", instr_pc_o, 32'h100);
        chk("mrst_addr", imem_addr_o, 32'h100);
        chk("mrst_v0", alg_data_0_vld_o, 1'b0);
        chk("mrst_ivld", instr_vld_o, 1'b0);
        rst_i = 1'b0;
        resp_delay = 1;
        expect_instr(32'h100, 32'h1234_5013);
        instr_rdy_i = 1'b1;
        drain(20);
        instr_rdy_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
